// File: rtl/adder_checker.sv
// adder_checker: queued scoreboard for adder DUVs.
// Compares reference results against a DUV of any latency.
module adder_checker #(
  parameter int N        = 2,
  parameter int TYPE     = 0,
  parameter int DEPTH    = 8,
  parameter int CNT_W    = 16,
  parameter int DRAIN_TO = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   end_of_test,
  input  logic                   exp_valid,
  input  logic                   exp_cin,
  input  logic [N-1:0]           exp_a,
  input  logic [N-1:0]           exp_b,
  input  logic [N-1:0]           exp_s,
  input  logic                   exp_cout,
  input  logic                   exp_prop,
  input  logic                   exp_gen,
  input  logic                   duv_valid,
  input  logic [N-1:0]           duv_s,
  input  logic                   duv_cout,
  input  logic                   duv_prop,
  input  logic                   duv_gen,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [CNT_W-1:0]       vec_count,
  output logic [CNT_W-1:0]       err_count,
  output logic                   sum_err,
  output logic                   cout_err,
  output logic                   pg_err,
  output logic                   ovf,
  output logic                   unf,
  output logic                   timeout,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       first_idx,
  output logic                   first_cin,
  output logic [N-1:0]           first_a,
  output logic [N-1:0]           first_b,
  output logic [N-1:0]           first_s_ref,
  output logic [N-1:0]           first_s_duv
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(DRAIN_TO + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic         cin;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] s;
    logic         cout;
    logic         prop;
    logic         gen;
  } ent_t;

  state_t state;
  state_t nxt;

  ent_t          mem [DEPTH];
  ent_t          wr_ent;
  ent_t          head;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [DW-1:0] drain_cnt;
  logic          seen;

  logic clr;
  logic push_en;
  logic pop_en;
  logic empty;
  logic full;
  logic do_pop;
  logic do_push;
  logic under;
  logic drop;
  logic s_ne;
  logic c_ne;
  logic pg_ne;
  logic mism;
  logic fail_ev;
  logic to_ev;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] x
  );
    return (&x) ? x : x + 1'b1;
  endfunction

  assign clr     = start & ((state == IDLE) | (state == DONE));
  assign push_en = exp_valid & (state == RUN);
  assign pop_en  = duv_valid & ((state == RUN) | (state == DRAIN));
  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop_en & ~empty;
  assign under   = pop_en & empty;
  assign do_push = push_en & (~full | do_pop);
  assign drop    = push_en & full & ~do_pop;

  assign wr_ent = '{
    cin:  exp_cin,
    a:    exp_a,
    b:    exp_b,
    s:    exp_s,
    cout: exp_cout,
    prop: exp_prop,
    gen:  exp_gen
  };

  assign head  = mem[rd_ptr];
  assign s_ne  = head.s != duv_s;
  assign c_ne  = head.cout != duv_cout;
  assign pg_ne = (TYPE == 1) &
                 ((head.prop != duv_prop) |
                  (head.gen != duv_gen));

  assign mism    = do_pop & (s_ne | c_ne | pg_ne);
  assign fail_ev = mism | under;

  assign to_ev = (state == DRAIN) & ~empty &
                 (drain_cnt == DW'(DRAIN_TO - 1));

  assign busy = (state == RUN) | (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done & (err_count == '0) &
                ~ovf & ~unf & ~timeout;

  // next-state logic for the run sequence
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (start) nxt = RUN;
      RUN:   if (end_of_test) nxt = DRAIN;
      DRAIN: begin
        if (empty) nxt = DONE;
        else if (to_ev) nxt = DONE;
      end
      DONE:  if (start) nxt = RUN;
    endcase
  end

  // state register and drain cycle counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= nxt;
      drain_cnt <= (state == DRAIN) ?
                   drain_cnt + 1'b1 : '0;
    end
  end

  // expected-entry storage; pointers alone define contents
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_ent;
  end

  // queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  // vector/error counters and sticky flags
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      vec_count <= '0;
      err_count <= '0;
      sum_err   <= 1'b0;
      cout_err  <= 1'b0;
      pg_err    <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      if (do_pop)  vec_count <= sat_inc(vec_count);
      if (fail_ev) err_count <= sat_inc(err_count);
      if (do_pop & s_ne)  sum_err  <= 1'b1;
      if (do_pop & c_ne)  cout_err <= 1'b1;
      if (do_pop & pg_ne) pg_err   <= 1'b1;
      if (drop)  ovf     <= 1'b1;
      if (under) unf     <= 1'b1;
      if (to_ev) timeout <= 1'b1;
    end
  end

  // first-failure snapshot, frozen until the next run
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      seen        <= 1'b0;
      first_idx   <= '0;
      first_cin   <= 1'b0;
      first_a     <= '0;
      first_b     <= '0;
      first_s_ref <= '0;
      first_s_duv <= '0;
    end else if (fail_ev && !seen) begin
      seen        <= 1'b1;
      first_idx   <= vec_count;
      first_s_duv <= duv_s;
      if (do_pop) begin
        first_cin   <= head.cin;
        first_a     <= head.a;
        first_b     <= head.b;
        first_s_ref <= head.s;
      end else begin
        first_cin   <= 1'b0;
        first_a     <= '0;
        first_b     <= '0;
        first_s_ref <= '0;
      end
    end
  end

endmodule

// File: tb/tb_adder_checker.sv
// tb_adder_checker: directed runs with a queued expectation
// scoreboard; TYPE=0 and TYPE=1 instances share stimulus.
module tb_adder_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       end_of_test = 1'b0;
  logic       exp_valid = 1'b0;
  logic       exp_cin = 1'b0;
  logic [1:0] exp_a = '0;
  logic [1:0] exp_b = '0;
  logic [1:0] exp_s = '0;
  logic       exp_cout = 1'b0;
  logic       exp_prop = 1'b0;
  logic       exp_gen = 1'b0;
  logic       duv_valid = 1'b0;
  logic [1:0] duv_s = '0;
  logic       duv_cout = 1'b0;
  logic       duv_prop = 1'b0;
  logic       duv_gen = 1'b0;

  logic        busy0, done0, pass0;
  logic [15:0] vec0, err0, fidx0;
  logic        sum0, cout0, pg0, ovf0, unf0, to0;
  logic [3:0]  level0;
  logic        fcin0;
  logic [1:0]  fa0, fb0, fsr0, fsd0;

  logic        busy1, done1, pass1;
  logic [15:0] vec1, err1, fidx1;
  logic        sum1, cout1, pg1, ovf1, unf1, to1;
  logic [3:0]  level1;
  logic        fcin1;
  logic [1:0]  fa1, fb1, fsr1, fsd1;

  adder_checker #(.N(2), .TYPE(0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .start(start), .end_of_test(end_of_test),
    .exp_valid(exp_valid), .exp_cin(exp_cin),
    .exp_a(exp_a), .exp_b(exp_b), .exp_s(exp_s),
    .exp_cout(exp_cout), .exp_prop(exp_prop),
    .exp_gen(exp_gen),
    .duv_valid(duv_valid), .duv_s(duv_s),
    .duv_cout(duv_cout), .duv_prop(duv_prop),
    .duv_gen(duv_gen),
    .busy(busy0), .done(done0), .pass(pass0),
    .vec_count(vec0), .err_count(err0),
    .sum_err(sum0), .cout_err(cout0), .pg_err(pg0),
    .ovf(ovf0), .unf(unf0), .timeout(to0),
    .level(level0), .first_idx(fidx0),
    .first_cin(fcin0), .first_a(fa0), .first_b(fb0),
    .first_s_ref(fsr0), .first_s_duv(fsd0)
  );

  adder_checker #(.N(2), .TYPE(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .start(start), .end_of_test(end_of_test),
    .exp_valid(exp_valid), .exp_cin(exp_cin),
    .exp_a(exp_a), .exp_b(exp_b), .exp_s(exp_s),
    .exp_cout(exp_cout), .exp_prop(exp_prop),
    .exp_gen(exp_gen),
    .duv_valid(duv_valid), .duv_s(duv_s),
    .duv_cout(duv_cout), .duv_prop(duv_prop),
    .duv_gen(duv_gen),
    .busy(busy1), .done(done1), .pass(pass1),
    .vec_count(vec1), .err_count(err1),
    .sum_err(sum1), .cout_err(cout1), .pg_err(pg1),
    .ovf(ovf1), .unf(unf1), .timeout(to1),
    .level(level1), .first_idx(fidx1),
    .first_cin(fcin1), .first_a(fa1), .first_b(fb1),
    .first_s_ref(fsr1), .first_s_duv(fsd1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [1:0] s;
    logic       c;
    logic       p;
    logic       g;
  } duvr_t;

  typedef struct packed {
    int busy; int done; int pass;
    int vec;  int err;
    int sum;  int cout; int pg;
    int ovf;  int unf;  int to;
    int level; int fidx; int fcin;
    int fa; int fb; int fsr; int fsd;
    int err1; int pg1; int pass1;
  } exp_t;

  exp_t  expq [$];
  string tagq [$];
  duvr_t pipe [3];
  logic  snap = 1'b0;
  logic  done_d = 1'b0;
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string t, input string f,
                     input logic [31:0] act,
                     input int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s.%s: got %0d want %0d",
               t, f, act, want);
    end
  endtask

  // monitor: pops one expectation per checkpoint or done rise
  always @(negedge clk) begin
    exp_t  e;
    string t;
    if (snap || (done0 === 1'b1 && !done_d)) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL monitor: no expectation queued");
      end else begin
        e = expq.pop_front();
        t = tagq.pop_front();
        chk(t, "busy", 32'(busy0), e.busy);
        chk(t, "done", 32'(done0), e.done);
        chk(t, "pass", 32'(pass0), e.pass);
        chk(t, "vec", 32'(vec0), e.vec);
        chk(t, "err", 32'(err0), e.err);
        chk(t, "sum_err", 32'(sum0), e.sum);
        chk(t, "cout_err", 32'(cout0), e.cout);
        chk(t, "pg_err", 32'(pg0), e.pg);
        chk(t, "ovf", 32'(ovf0), e.ovf);
        chk(t, "unf", 32'(unf0), e.unf);
        chk(t, "timeout", 32'(to0), e.to);
        chk(t, "level", 32'(level0), e.level);
        chk(t, "first_idx", 32'(fidx0), e.fidx);
        chk(t, "first_cin", 32'(fcin0), e.fcin);
        chk(t, "first_a", 32'(fa0), e.fa);
        chk(t, "first_b", 32'(fb0), e.fb);
        chk(t, "first_s_ref", 32'(fsr0), e.fsr);
        chk(t, "first_s_duv", 32'(fsd0), e.fsd);
        chk(t, "t1_err", 32'(err1), e.err1);
        chk(t, "t1_pg_err", 32'(pg1), e.pg1);
        chk(t, "t1_pass", 32'(pass1), e.pass1);
      end
    end
    done_d <= (done0 === 1'b1);
  end

  function automatic duvr_t refadd(input logic [1:0] a,
                                   input logic [1:0] b);
    duvr_t      r;
    logic [2:0] t;
    t   = {1'b0, a} + {1'b0, b};
    r.v = 1'b1;
    r.s = t[1:0];
    r.c = t[2];
    r.p = &(a ^ b);
    r.g = t[2];
    return r;
  endfunction

  function automatic exp_t zero();
    exp_t e;
    e = '0;
    return e;
  endfunction

  // one clock of stimulus; DUV model is a 3-deep pipe
  task automatic step(input bit push,
                      input logic [1:0] a,
                      input logic [1:0] b,
                      input bit den, input bit cs,
                      input bit cg, input bit frc,
                      input duvr_t fv);
    duvr_t r;
    duvr_t nd;
    duvr_t o;
    r         = refadd(a, b);
    exp_valid = push;
    exp_cin   = 1'b0;
    exp_a     = a;
    exp_b     = b;
    exp_s     = r.s;
    exp_cout  = r.c;
    exp_prop  = r.p;
    exp_gen   = r.g;
    nd        = r;
    nd.v      = push & den;
    nd.s      = r.s ^ {1'b0, cs};
    nd.g      = r.g ^ cg;
    o         = frc ? fv : pipe[2];
    duv_valid = o.v;
    duv_s     = o.s;
    duv_cout  = o.c;
    duv_prop  = o.p;
    duv_gen   = o.g;
    pipe[2]   = pipe[1];
    pipe[1]   = pipe[0];
    pipe[0]   = nd;
    @(posedge clk);
    #1;
    exp_valid   = 1'b0;
    duv_valid   = 1'b0;
    start       = 1'b0;
    end_of_test = 1'b0;
  endtask

  task automatic idle();
    step(0, 2'd0, 2'd0, 0, 0, 0, 0, '0);
  endtask

  task automatic pop_empty(input logic [1:0] s);
    duvr_t f;
    f   = '0;
    f.v = 1'b1;
    f.s = s;
    step(0, 2'd0, 2'd0, 0, 0, 0, 1, f);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    idle();
  endtask

  task automatic pulse_eot();
    end_of_test = 1'b1;
    idle();
  endtask

  task automatic expect_done(input exp_t e,
                             input string t);
    expq.push_back(e);
    tagq.push_back(t);
  endtask

  task automatic checkpoint(input exp_t e,
                            input string t);
    expq.push_back(e);
    tagq.push_back(t);
    snap = 1'b1;
    @(negedge clk);
    #1;
    snap = 1'b0;
  endtask

  task automatic wait_done(input string t,
                           output int n);
    n = 0;
    while (done0 !== 1'b1 && n < 200) begin
      @(negedge clk);
      if (done0 !== 1'b1) n++;
    end
    if (done0 !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s.wait_done: got %0d want 1",
               t, done0);
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t  e;
    duvr_t f;
    int    n;
    for (int i = 0; i < 3; i++) pipe[i] = '0;

    rst_n = 1'b0;
    idle();
    idle();
    rst_n = 1'b1;
    checkpoint(zero(), "reset");

    // all-correct run, latency 3
    pulse_start();
    for (int i = 0; i < 16; i++)
      step(1, i[3:2], i[1:0], 1, 0, 0, 0, '0);
    repeat (3) idle();
    e = zero();
    e.done = 1; e.pass = 1; e.vec = 16; e.pass1 = 1;
    expect_done(e, "clean");
    pulse_eot();
    wait_done("clean", n);

    // sum corrupted on vector 5 (a=1,b=1)
    pulse_start();
    for (int i = 0; i < 16; i++)
      step(1, i[3:2], i[1:0], 1, (i == 5), 0, 0, '0);
    repeat (3) idle();
    e = zero();
    e.done = 1; e.vec = 16; e.err = 1; e.sum = 1;
    e.fidx = 5; e.fa = 1; e.fb = 1;
    e.fsr = 2; e.fsd = 3; e.err1 = 1;
    expect_done(e, "sumbad");
    pulse_eot();
    wait_done("sumbad", n);

    // gen corrupted on a=3,b=1: only TYPE=1 sees it
    pulse_start();
    for (int i = 0; i < 16; i++)
      step(1, i[3:2], i[1:0], 1, 0, (i == 13), 0, '0);
    repeat (3) idle();
    e = zero();
    e.done = 1; e.pass = 1; e.vec = 16;
    e.err1 = 1; e.pg1 = 1;
    expect_done(e, "genbad");
    pulse_eot();
    wait_done("genbad", n);

    // overflow, then push+pop while full
    pulse_start();
    for (int i = 0; i < 9; i++)
      step(1, i[3:2], i[1:0], 0, 0, 0, 0, '0);
    e = zero();
    e.busy = 1; e.ovf = 1; e.level = 8;
    checkpoint(e, "ovf");
    f = refadd(2'd0, 2'd0);
    step(1, 2'd1, 2'd2, 0, 0, 0, 1, f);
    e.vec = 1;
    checkpoint(e, "fullpp");
    e.busy = 0; e.done = 1; e.to = 1;
    expect_done(e, "ovf_to");
    pulse_eot();
    wait_done("ovf_to", n);

    // underflow, then drain timeout
    pulse_start();
    pop_empty(2'd1);
    e = zero();
    e.busy = 1; e.unf = 1; e.err = 1;
    e.fsd = 1; e.err1 = 1;
    checkpoint(e, "unf");
    step(1, 2'd2, 2'd3, 0, 0, 0, 0, '0);
    step(1, 2'd1, 2'd0, 0, 0, 0, 0, '0);
    e.busy = 0; e.done = 1; e.to = 1; e.level = 2;
    expect_done(e, "drain_to");
    pulse_eot();
    wait_done("drain_to", n);
    chk("drain_to", "cycles", 32'(n), 64);

    // reset mid-run
    pulse_start();
    pop_empty(2'd2);
    pop_empty(2'd2);
    for (int i = 0; i < 4; i++)
      step(1, i[3:2], i[1:0], 0, 0, 0, 0, '0);
    e = zero();
    e.busy = 1; e.unf = 1; e.err = 2; e.level = 4;
    e.fsd = 2; e.err1 = 2;
    checkpoint(e, "pre_rst");
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
    checkpoint(zero(), "post_rst");
    f = refadd(2'd1, 2'd1);
    step(1, 2'd1, 2'd1, 0, 0, 0, 1, f);
    checkpoint(zero(), "idle_ign");

    repeat (2) idle();
    chk("end", "queue_left", 32'(expq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_checker.md
Name: adder_checker

Overview:
Synchronous, self-checking scoreboard for adder verification. It queues expected results from the reference adder and compares them against a DUV that has arbitrary latency, including pipelined DUVs. It counts vectors and mismatches per field and keeps a snapshot of the first failure. It replaces the per-cycle inline comparison in the adder benches and sits between the stimulus/reference side and the log writer.

Parameters:
N, 2, operand and sum width in bits
TYPE, 0, 0 = check sum and cout only; 1 = also check prop and gen
DEPTH, 8, expected-queue depth in entries (power of 2, minimum 2)
CNT_W, 16, width of the vector and error counters
DRAIN_TO, 64, maximum number of cycles DRAIN waits for the queue to empty

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begins a run
end_of_test  in  1  one-cycle pulse; no more stimulus follows
exp_valid  in  1  push an expected entry
exp_cin  in  1  stimulus carry-in (stored for the snapshot)
exp_a, exp_b  in  N  stimulus operands (stored for the snapshot)
exp_s  in  N  reference sum
exp_cout, exp_prop, exp_gen  in  1 each  reference carry-out, propagate, generate
duv_valid  in  1  DUV result valid; pops the queue head
duv_s  in  N  DUV sum
duv_cout, duv_prop, duv_gen  in  1 each  DUV carry-out, propagate, generate
busy  out  1  high in RUN or DRAIN
done  out  1  high in DONE
pass  out  1  see Behaviour
vec_count  out  CNT_W  number of compared vectors
err_count  out  CNT_W  number of mismatching vectors plus underflow events
sum_err, cout_err, pg_err  out  1 each  sticky per-field mismatch flags
ovf, unf, timeout  out  1 each  sticky error flags
level  out  log2(DEPTH)+1  current queue occupancy
first_idx  out  CNT_W  vec_count value of the first failing vector
first_cin, first_a, first_b, first_s_ref, first_s_duv  out  1/N/N/N/N  snapshot of the first failing vector

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - Every output goes to 0, the queue empties and level=0.
  - Reset mid-run aborts the run with no residue.
- IDLE:
  - exp_valid and duv_valid are ignored.
  - start -> RUN. On entry, all counters, sticky flags, the snapshot and the queue are cleared.
- RUN:
  - exp_valid pushes the entry {cin,a,b,s,cout,prop,gen}.
  - duv_valid pops the head and compares it against the DUV inputs in the same cycle.
  - end_of_test -> DRAIN.
  - start while in RUN is ignored.
- DRAIN:
  - Pushes are ignored; pops and compares continue.
  - Moves to DONE when level==0.
  - If DRAIN_TO cycles elapse first: timeout=1 and the state moves to DONE.
- DONE:
  - All outputs hold their values.
  - start -> RUN, with the same clearing as on entry from IDLE.
- Compare (on a pop with level>0):
  - vec_count increments, saturating at 2^CNT_W-1.
  - A mismatch is exp_s!=duv_s, or exp_cout!=duv_cout, or (TYPE==1 and (prop or gen differ)).
  - On a mismatch: err_count increments (saturating) and the matching sticky flags set.
  - When TYPE==0, pg_err stays 0.
- Snapshot:
  - Captured on the first mismatch or first underflow of a run; first_idx takes the pre-increment vec_count.
  - Never overwritten until the next start.
- Queue:
  - Push and pop in the same cycle while full: both happen and level is unchanged.
  - Push and pop in the same cycle while empty: the pop is an underflow; the push still takes effect, so level becomes 1.
  - Push while full with no pop: entry dropped and ovf=1.
  - Pop while empty: unf=1, err_count increments and vec_count does not change.
  - Read and write pointers wrap modulo DEPTH.
- Registered outputs:
  - All outputs are registered.
  - Counters and flags reflect a compare one cycle after the duv_valid edge.
- pass = done & (err_count==0) & ~ovf & ~unf & ~timeout.

Test Plan:
- N=2, TYPE=0. After start, push 16 entries covering all {a,b} with cin=0, using correct DUV results at latency 3, then end_of_test -> done=1, pass=1, vec_count=16, err_count=0, level=0 at DONE.
- Corrupt the DUV on vector 5 (a=1,b=1,cin=0: exp_s=2, DUV gives duv_s=3) -> sum_err=1, err_count=1, first_idx=5, first_a=1, first_b=1, first_s_ref=2, first_s_duv=3, pass=0.
- TYPE=1: DUV gives gen=0 for a=3,b=1 (expected gen=1) -> pg_err=1, err_count=1. The same stimulus with TYPE=0 -> pg_err=0, pass=1.
- DEPTH=8: push 9 entries with no pop -> ovf=1 on the 9th and level=8. Then push and pop simultaneously at level=8 -> level stays 8, ovf unchanged.
- duv_valid with the queue empty -> unf=1, err_count=1, vec_count unchanged. Push 2 entries, send end_of_test, and withhold the DUV -> timeout=1 after 64 cycles, done=1, pass=0.
- Assert rst_n=0 in RUN with level=4 and err_count=2 -> next cycle all outputs are 0, state is IDLE, and duv_valid is ignored until start.
